// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and default widths for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Data-over-fetch priority with a saturating starvation counter that forces
// a fetch grant once data has won STARVE_MAX times in a row against it.
module mem_arb_prio
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic accept_i,
  output logic grant_valid_o,
  output logic grant_sel_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Pick the winner from the live requests each cycle.
  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_sel_o   = GNT_INST;
    if (d_req_i && !(i_req_i && starve_q == CNT_MAX)) begin
      grant_sel_o = GNT_DATA;
    end
  end

  // Count data wins over a waiting fetch; any other grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (accept_i) begin
      if (grant_sel_o == GNT_DATA && i_req_i) begin
        starve_d = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// one transaction in flight at a time.
//
// state | meaning
// IDLE  | arbitrate live requests, accept winner (x_addr_ok) this cycle
// ADDR  | present latched request downstream, wait for m_addr_ok
// DATA  | wait for m_data_ok, capture read data for loads
// RESP  | pulse granted requester's x_data_ok, then back to IDLE
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic grant_valid, grant_sel, accept;

  // Acceptance is suppressed while rst is high so outputs stay quiet in reset.
  assign accept = (state_q == ST_IDLE) && grant_valid && !rst;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk           (clk),
    .rst           (rst),
    .i_req_i       (i_req),
    .d_req_i       (d_req),
    .accept_i      (accept),
    .grant_valid_o (grant_valid),
    .grant_sel_o   (grant_sel)
  );

  // Next-state and latch updates for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR;
          grant_d = grant_sel;
          if (grant_sel == GNT_DATA) begin
            wr_d    = d_wr;
            wstrb_d = d_wstrb;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            wr_d    = 1'b0;
            wstrb_d = '0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      ST_ADDR: if (m_addr_ok) state_d = ST_DATA;
      ST_DATA: begin
        if (m_data_ok) begin
          state_d = ST_RESP;
          if (!wr_q) rdata_d = m_rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_INST;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign i_addr_ok = accept && (grant_sel == GNT_INST);
  assign d_addr_ok = accept && (grant_sel == GNT_DATA);
  assign i_data_ok = (state_q == ST_RESP) && (grant_q == GNT_INST);
  assign d_data_ok = (state_q == ST_RESP) && (grant_q == GNT_DATA);
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;

  // Downstream fields come straight from the latches; only m_req is gated.
  assign m_req   = (state_q == ST_ADDR);
  assign m_wr    = wr_q;
  assign m_wstrb = wstrb_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (read-only) and the data requester (load/store).
- One transaction is outstanding at a time, sequenced by a 4-state FSM over a req/addr_ok/data_ok handshake.
- Data has priority over fetch, with a starvation guard so fetch is never locked out.
- Sits between the CPU core pipeline (IF and MEM stages) and the memory/bridge inside the top-level CPU.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_MAX, 4, max consecutive data grants while i_req is pending before fetch is forced; must be ≥1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_addr_ok.
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  1-cycle pulse: fetch request accepted.
- i_data_ok  out  1  1-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held with its fields stable until d_addr_ok.
- d_wr  in  1  1 = store, 0 = load.
- d_wstrb  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_addr_ok  out  1  1-cycle pulse: data request accepted.
- d_data_ok  out  1  1-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  load data.
- m_req  out  1  downstream request.
- m_wr  out  1  downstream write.
- m_wstrb  out  DATA_W/8  downstream byte enables.
- m_addr  out  ADDR_W  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_addr_ok  in  1  downstream accepted m_req.
- m_data_ok  in  1  downstream completion; m_rdata valid.
- m_rdata  in  DATA_W  downstream read data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, grant=INST, starve_cnt=0; latched wr/wstrb/addr/wdata/rdata=0.
  - All outputs 0 on the following cycle.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If d_req or i_req, arbitrate combinationally and pulse the winner's x_addr_ok in this same cycle.
  - Latch the winner's fields (inst: wr=0, wstrb=0, wdata=0), record grant, go to ADDR.
  - No request: stay in IDLE.
- Arbitration:
  - Only d_req → data. Only i_req → inst.
  - Both → data, unless starve_cnt==STARVE_MAX, in which case inst.
- starve_cnt, updated at each grant:
  - Data granted while i_req=1 → +1 (saturating at STARVE_MAX).
  - Inst granted, or data granted with i_req=0 → 0.
- ADDR:
  - m_req=1; m_wr/m_wstrb/m_addr/m_wdata driven from latched registers.
  - m_addr_ok=1 → DATA; otherwise hold, with outputs stable.
- DATA:
  - m_req=0. Wait for m_data_ok.
  - On m_data_ok: capture m_rdata into the rdata register only if latched wr=0 (stores leave it unchanged); go to RESP.
  - m_data_ok seen in ADDR or IDLE is ignored (protocol violation).
- RESP:
  - Pulse the granted requester's x_data_ok for exactly one cycle; go to IDLE.
  - No new acceptance happens in RESP.
- Read data outputs:
  - i_rdata and d_rdata both continuously drive the rdata register.
  - Requesters sample only on their own data_ok.
- Latency:
  - Minimum acceptance to data_ok is 3 cycles (IDLE→ADDR→DATA→RESP), when m_addr_ok and m_data_ok arrive at the earliest cycle.
  - Back-to-back transactions: 4 cycles each minimum.
- Only one of i_addr_ok/d_addr_ok is ever high, and only in IDLE. Likewise only one data_ok, only in RESP.
- Reset mid-transaction:
  - Abandons the transaction with no data_ok pulse.
  - The downstream memory shares rst, so no stale m_data_ok follows.
- A requester dropping req before addr_ok is permitted; arbitration is re-evaluated each IDLE cycle.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3.
  - Grant encoding: GNT_INST=1'b0, GNT_DATA=1'b1.
  - Default widths.
- One sub-module is natural: mem_arb_prio.
  - Combinational priority plus the saturating starve counter.
  - Outputs: grant_valid, grant_sel.
- FSM, latches and port muxing stay in mem_bus_arbiter.

Test Plan:
- Reset: hold rst 2 cycles with i_req=1 → all outputs 0. First cycle after release: i_addr_ok=1, state→ADDR.
- Single fetch: i_addr=0xBFC00000, memory responds with m_addr_ok and m_data_ok at the earliest cycle, m_rdata=0x3C080001 → m_addr=0xBFC00000, m_wr=0; i_data_ok pulses 3 cycles after i_addr_ok with i_rdata=0x3C080001.
- Store: d_wr=1, d_wstrb=4'b0011, d_addr=0x80000010, d_wdata=0xDEADBEEF → m_wstrb=4'b0011 and m_wdata=0xDEADBEEF while m_req=1; d_data_ok pulses once; d_rdata unchanged.
- Simultaneous requests: i_req and d_req both held from cycle 0 → d_addr_ok first, i_addr_ok in the next IDLE; i_addr_ok and d_addr_ok never high together.
- Starvation: STARVE_MAX=4, i_req and d_req held continuously → grant sequence D,D,D,D,I,D,D,D,D,I.
- Stall plus mid-op reset: m_addr_ok withheld 5 cycles → m_req and m_addr stable throughout. Assert rst while in DATA → next cycle IDLE with outputs 0, and no data_ok ever issued for that transaction.
